// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO with a valid/ready push port; frames are sent LSB-first.
// Define UART_TX_PARITY_EN to add a parity bit (even, or odd when PARITY_ODD=1) after the data bits.
module uart_tx_fifo #(
  parameter int DELAY_FRAMES = 234,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DELAY_FRAMES);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DELAY_FRAMES - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DATA_BITS - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

`ifdef UART_TX_PARITY_EN
  function automatic logic parity_f(input logic [DATA_BITS-1:0] word);
    return (^word) ^ 1'(PARITY_ODD);
  endfunction
`endif

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wptr_r, rptr_r;
  logic [AW:0]          count_r, count_nxt_s;
  logic [2:0]           state_r, state_nxt_s;
  logic [CW-1:0]        cnt_r, cnt_nxt_s;
  logic [IW-1:0]        idx_r, idx_nxt_s;
  logic                 stop_r, stop_nxt_s;
  logic [DATA_BITS-1:0] shift_r;
  logic                 uart_tx_r, busy_r, tx_ready_r;
  logic                 line_s, tick_s, push_s, pop_s;

  assign tx_ready   = tx_ready_r;
  assign uart_tx    = uart_tx_r;
  assign busy       = busy_r;
  assign fifo_count = count_r;

  // Handshake and pop qualification; a pop only happens when the line is free for a new frame.
  always_comb begin
    tick_s = (cnt_r == CNT_MAX);
    push_s = tx_valid && tx_ready_r;
    pop_s  = (count_r != {(AW+1){1'b0}}) &&
             ((state_r == ST_IDLE) ||
              ((state_r == ST_STOP) && tick_s && (stop_r == STOP_LAST)));
  end

  // FIFO occupancy update.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + (AW+1)'(1);
      2'b01:   count_nxt_s = count_r - (AW+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Frame sequencer: next state, bit timing and the line value for this cycle.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    stop_nxt_s  = stop_r;
    cnt_nxt_s   = tick_s ? {CW{1'b0}} : cnt_r + CW'(1);
    line_s      = 1'b1;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = {CW{1'b0}};
        if (pop_s) state_nxt_s = ST_START;
        else       state_nxt_s = ST_IDLE;
      end
      ST_START: begin
        line_s = 1'b0;
        if (tick_s) begin
          state_nxt_s = ST_DATA;
          idx_nxt_s   = {IW{1'b0}};
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        line_s = shift_r[idx_r];
        if (tick_s && (idx_r == IDX_MAX)) begin
`ifdef UART_TX_PARITY_EN
          state_nxt_s = ST_PARITY;
`else
          state_nxt_s = ST_STOP;
`endif
          stop_nxt_s  = 1'b0;
        end else if (tick_s) begin
          idx_nxt_s = idx_r + IW'(1);
        end else begin
          idx_nxt_s = idx_r;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        line_s = parity_f(shift_r);
        if (tick_s) begin
          state_nxt_s = ST_STOP;
          stop_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        line_s = 1'b1;
        // Back-to-back frames: the last stop cycle hands straight over to the next start bit.
        if (tick_s && (stop_r == STOP_LAST)) begin
          if (pop_s) state_nxt_s = ST_START;
          else       state_nxt_s = ST_IDLE;
        end else if (tick_s) begin
          stop_nxt_s = 1'b1;
        end else begin
          stop_nxt_s = stop_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CW{1'b0}};
      end
    endcase
  end

  // FIFO storage; contents need no reset because the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_s && !rst) mem_r[wptr_r] <= tx_data;
  end

  // Control registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CW{1'b0}};
      idx_r      <= {IW{1'b0}};
      stop_r     <= 1'b0;
      shift_r    <= {DATA_BITS{1'b0}};
      wptr_r     <= {AW{1'b0}};
      rptr_r     <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      uart_tx_r  <= 1'b1;
      busy_r     <= 1'b0;
      tx_ready_r <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      idx_r      <= idx_nxt_s;
      stop_r     <= stop_nxt_s;
      count_r    <= count_nxt_s;
      uart_tx_r  <= line_s;
      busy_r     <= (state_nxt_s != ST_IDLE) || (count_nxt_s != {(AW+1){1'b0}});
      tx_ready_r <= (count_nxt_s != DEPTH_C);
      if (push_s) wptr_r <= wptr_r + AW'(1);
      if (pop_s) begin
        rptr_r  <= rptr_r + AW'(1);
        shift_r <= mem_r[rptr_r];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two configurations, a serial-line decoder per DUT and a word scoreboard.
module tb_uart_tx_fifo;
  localparam int D = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME1 = (1 + 8 + P + 1) * D;
  localparam int FRAME2 = (1 + 7 + P + 2) * D;

  typedef struct {
    logic [8:0] word;
    logic       par;
    logic       ok;
    int         sc;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data1;
  logic [6:0] data2;
  logic       valid1, valid2, ready1, ready2, line0, line1, busy1, busy2;
  logic [2:0] cnt1, cnt2;
  int         cyc = 0;
  int         ncmp = 0;
  int         nfail = 0;
  int         last_push;
  int         st[16];
  frame_t     rxq0[$], rxq1[$];
  logic [8:0] expq0[$], expq1[$];

  uart_tx_fifo #(.DELAY_FRAMES(D), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst(rst), .tx_data(data1), .tx_valid(valid1), .tx_ready(ready1),
    .uart_tx(line0), .busy(busy1), .fifo_count(cnt1));

  uart_tx_fifo #(.DELAY_FRAMES(D), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(1)) dut2 (
    .clk(clk), .rst(rst), .tx_data(data2), .tx_valid(valid2), .tx_ready(ready2),
    .uart_tx(line1), .busy(busy2), .fifo_count(cnt2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial decoder: every bit must hold for exactly D samples; start low, stop bits high.
  task automatic rx(input int w);
    int db, sb, nbits;
    logic v, cur, abort;
    frame_t f;
    db = (w == 0) ? 8 : 7;
    sb = (w == 0) ? 1 : 2;
    nbits = 1 + db + P + sb;
    forever begin
      @(negedge clk);
      cur = (w == 0) ? line0 : line1;
      if (rst === 1'b0 && cur === 1'b0) begin
        f.sc = cyc; f.ok = 1'b1; f.word = 9'h000; f.par = 1'b0; abort = 1'b0; v = 1'b0;
        for (int b = 0; b < nbits && !abort; b++) begin
          for (int s = 0; s < D; s++) begin
            if (!(b == 0 && s == 0)) @(negedge clk);
            if (rst !== 1'b0) begin abort = 1'b1; break; end
            cur = (w == 0) ? line0 : line1;
            if (s == 0) v = cur;
            else if (cur !== v) f.ok = 1'b0;
          end
          if (!abort) begin
            if (b == 0 && v !== 1'b0) f.ok = 1'b0;
            else if (b >= 1 && b <= db) f.word[b-1] = v;
            else if (P == 1 && b == db + 1) f.par = v;
            else if (b > db + P && v !== 1'b1) f.ok = 1'b0;
          end
        end
        if (!abort) begin
          if (w == 0) rxq0.push_back(f);
          else        rxq1.push_back(f);
        end
      end
    end
  endtask

  initial rx(0);
  initial rx(1);

  task automatic push(input int w, input logic [8:0] d);
    logic got;
    got = 1'b0;
    if (w == 0) begin data1 = d[7:0]; valid1 = 1'b1; end
    else        begin data2 = d[6:0]; valid2 = 1'b1; end
    for (int i = 0; i < 400 && !got; i++) begin
      got = (w == 0) ? ready1 : ready2;
      @(posedge clk);
      @(negedge clk);
    end
    valid1 = 1'b0;
    valid2 = 1'b0;
    chk("push_accept", 32'(got), 32'(1'b1));
    if (got && w == 0) expq0.push_back(d & 9'h0FF);
    else if (got)      expq1.push_back(d & 9'h07F);
    else               ;
    last_push = cyc;
  endtask

  task automatic drain(input int w, input int n);
    frame_t f;
    logic [8:0] e;
    int have;
    for (int i = 0; i < n * 60 + 200; i++) begin
      have = (w == 0) ? rxq0.size() : rxq1.size();
      if (have >= n) break;
      @(negedge clk);
    end
    have = (w == 0) ? rxq0.size() : rxq1.size();
    chk("rx_frame_count", 32'(have), 32'(n));
    for (int i = 0; i < have && i < n; i++) begin
      if (w == 0) begin f = rxq0.pop_front(); e = expq0.pop_front(); end
      else        begin f = rxq1.pop_front(); e = expq1.pop_front(); end
      chk("rx_word", 32'(f.word), 32'(e));
      chk("rx_framing", 32'(f.ok), 32'(1'b1));
`ifdef UART_TX_PARITY_EN
      chk("rx_parity", 32'(f.par), 32'((($countones(e) % 2) == 1) ^ (w == 1)));
`endif
      st[i] = f.sc;
    end
  endtask

  initial begin
    logic [8:0] r;
    int s0;
    rst = 1'b1; valid1 = 1'b0; valid2 = 1'b0; data1 = 8'h00; data2 = 7'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_uart_tx", 32'(line0), 32'(1'b1));
    chk("rst_busy", 32'(busy1), 32'(1'b0));
    chk("rst_count", 32'(cnt1), 32'(3'd0));
    chk("rst_ready", 32'(ready1), 32'(1'b1));
    chk("rst_uart_tx2", 32'(line1), 32'(1'b1));
    chk("rst_busy2", 32'(busy2), 32'(1'b0));
    chk("rst_count2", 32'(cnt2), 32'(3'd0));

    // Single frame, start-bit latency, busy release.
    push(0, 9'h055);
    chk("busy_after_push", 32'(busy1), 32'(1'b1));
    s0 = last_push;
    drain(0, 1);
    chk("start_latency", 32'(st[0] - s0), 32'(2));
    repeat (2) @(negedge clk);
    chk("busy_idle", 32'(busy1), 32'(1'b0));

    // Back-to-back words: no idle gap, occupancy peaks at two.
    push(0, 9'h001); push(0, 9'h002); push(0, 9'h003);
    chk("burst_peak_count", 32'(cnt1), 32'(3'd2));
    drain(0, 3);
    chk("gap_1_2", 32'(st[1] - st[0]), 32'(FRAME1));
    chk("gap_2_3", 32'(st[2] - st[1]), 32'(FRAME1));

    // Fill to full while holding valid; nothing lost or duplicated.
    for (int k = 0; k < 5; k++) push(0, 9'($urandom));
    chk("full_count", 32'(cnt1), 32'(3'd4));
    chk("full_ready", 32'(ready1), 32'(1'b0));
    r = 9'($urandom);
    data1 = r[7:0]; valid1 = 1'b1;
    repeat (8) @(negedge clk);
    chk("full_hold_count", 32'(cnt1), 32'(3'd4));
    chk("full_hold_ready", 32'(ready1), 32'(1'b0));
    push(0, r);
    drain(0, 6);

    // 0x07 into both configurations (parity bit 1 even / 0 odd when enabled).
    push(0, 9'h007); push(1, 9'h007);
    drain(0, 1); drain(1, 1);

    // Seven data bits, two stop bits, second frame follows with no gap.
    push(1, 9'h07F); push(1, 9'($urandom));
    drain(1, 2);
    chk("gap_two_stop", 32'(st[1] - st[0]), 32'(FRAME2));

    // Reset during data bit 3 abandons the frame and flushes the FIFO.
    push(0, 9'h0A5); push(0, 9'h03C);
    for (int i = 0; i < 100 && line0 !== 1'b0; i++) @(negedge clk);
    if (line0 !== 1'b0) begin
      nfail++;
      $error("FAIL start_wait: timed out waiting for the start bit");
    end
    chk("start_seen", 32'(line0), 32'(1'b0));
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_uart_tx", 32'(line0), 32'(1'b1));
    chk("midrst_count", 32'(cnt1), 32'(3'd0));
    chk("midrst_busy", 32'(busy1), 32'(1'b0));
    chk("midrst_ready", 32'(ready1), 32'(1'b1));
    @(negedge clk);
    rst = 1'b0;
    expq0.delete();
    rxq0.delete();
    push(0, 9'($urandom));
    drain(0, 1);

    // Random words with random idle spacing.
    for (int k = 0; k < 12; k++) begin
      push(0, 9'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain(0, 12);
    for (int k = 0; k < 4; k++) begin
      push(1, 9'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain(1, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
